// File: rtl/cmp_pkg.sv
// Shared definitions for the operand entry block and the 8-bit magnitude
// compare datapath: state encodings and operand/nibble widths.
package cmp_pkg;

    localparam int STATE_W   = 3;
    localparam int NIBBLE_W  = 4;
    localparam int OPERAND_W = 8;

    // Encodings are visible on stage_o (LEDs). 5..7 are illegal.
    typedef enum logic [STATE_W-1:0] {
        ST_A_LO = 3'd0,
        ST_A_HI = 3'd1,
        ST_B_LO = 3'd2,
        ST_B_HI = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/operand_entry_fsm_debounce.sv
// btn_debounce: turns a raw, bouncy, asynchronous pushbutton into a single
// one-cycle press pulse per physical press (rising edge only).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   btn_i    in   raw pushbutton, active-high
//   press_o  out  registered one-cycle pulse per accepted press
//
// Build option OPERAND_ENTRY_DEBOUNCE_EN:
//   defined   - level is accepted only after DEBOUNCE_CYCLES stable cycles
//   undefined - level follows the synchronised button directly (simulation)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_check
        $error("btn_debounce: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
    end

    logic btn_meta;
    logic btn_sync;
    logic btn_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_i;
            btn_sync <= btn_meta;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             btn_db_q;

    // Any cycle of agreement restarts the count, so a bounce shorter than
    // DEBOUNCE_CYCLES never reaches the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (btn_sync == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            btn_db <= btn_sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_q <= 1'b0;
            press_o  <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            press_o  <= btn_db & ~btn_db_q;
        end
    end
`else
    // Without filtering btn_db is just btn_sync one cycle late, so the edge
    // is taken between btn_sync and btn_db; press_o then lands 3 cycles
    // after btn_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db  <= 1'b0;
            press_o <= 1'b0;
        end else begin
            btn_db  <= btn_sync;
            press_o <= btn_sync & ~btn_db;
        end
    end
`endif

endmodule

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: builds operands A and B for the magnitude comparator,
// one switch nibble per accepted button press.
//
//   state   | meaning
//   --------+---------------------------------------------
//   A_LO    | waiting for press to load a_o[3:0]
//   A_HI    | waiting for press to load a_o[7:4]
//   B_LO    | waiting for press to load b_o[3:0]
//   B_HI    | waiting for press to load b_o[7:4]
//   DONE    | both operands valid; next press clears all
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   btn_i        raw pushbutton (asynchronous, bouncy)
//   sw_i [3:0]   nibble switches (asynchronous)
//   a_o, b_o     registered operands
//   valid_o      high while in DONE
//   stage_o      current state encoding
//   press_o      one-cycle pulse per accepted press
//
// Build option OPERAND_ENTRY_DEBOUNCE_EN selects the debounce filter in
// btn_debounce; everything here is identical in both builds.
import cmp_pkg::*;

module operand_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_i,
    input  logic [NIBBLE_W-1:0]  sw_i,
    output logic [OPERAND_W-1:0] a_o,
    output logic [OPERAND_W-1:0] b_o,
    output logic                 valid_o,
    output logic [STATE_W-1:0]   stage_o,
    output logic                 press_o
);

    logic                 press;
    logic [NIBBLE_W-1:0]  sw_meta;
    logic [NIBBLE_W-1:0]  sw_sync;
    state_t               state_q;
    state_t               state_d;
    logic [OPERAND_W-1:0] a_q;
    logic [OPERAND_W-1:0] a_d;
    logic [OPERAND_W-1:0] b_q;
    logic [OPERAND_W-1:0] b_d;
    logic                 valid_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_i),
        .press_o (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_A_LO;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_A_LO: if (press) begin
                a_d[NIBBLE_W-1:0] = sw_sync;
                state_d           = ST_A_HI;
            end
            ST_A_HI: if (press) begin
                a_d[OPERAND_W-1:NIBBLE_W] = sw_sync;
                state_d                   = ST_B_LO;
            end
            ST_B_LO: if (press) begin
                b_d[NIBBLE_W-1:0] = sw_sync;
                state_d           = ST_B_HI;
            end
            ST_B_HI: if (press) begin
                b_d[OPERAND_W-1:NIBBLE_W] = sw_sync;
                state_d                   = ST_DONE;
            end
            ST_DONE: if (press) begin
                a_d     = '0;
                b_d     = '0;
                state_d = ST_A_LO;
            end
            default: begin
                a_d     = '0;
                b_d     = '0;
                state_d = ST_A_LO;
            end
        endcase
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign valid_o = valid_q;
    assign stage_o = state_q;
    assign press_o = press;

endmodule
